// File: rtl/noc_timeout_bank.sv
// noc_timeout_bank: per-channel watchdog counters for the 3x3 NoC router.
// Each channel has its own enable, clear, sticky timeout flag, one-cycle
// expiry pulse and optional auto-reload. A fixed-priority encoder reports
// the lowest-numbered expired channel.
module noc_timeout_bank #(
  parameter int NUM_CH = 5,
  parameter int WIDTH  = 10,
  parameter int RELOAD = 0,
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [WIDTH-1:0]        limit,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       timeout_pulse,
  output logic                    any_timeout,
  output logic [ID_W-1:0]         first_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t           r_state     [NUM_CH];
  state_t           w_state_nxt [NUM_CH];
  logic [WIDTH-1:0] r_count     [NUM_CH];
  logic [WIDTH-1:0] w_count_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_timeout;
  logic [NUM_CH-1:0] w_timeout_nxt;
  logic [NUM_CH-1:0] r_pulse;
  logic [NUM_CH-1:0] w_pulse_nxt;
  logic [NUM_CH-1:0] w_run;
  logic [ID_W-1:0]   w_first_id;

  // State registers for every channel; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_count[i] <= '0;
      end
      r_timeout <= '0;
      r_pulse   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_count[i] <= w_count_nxt[i];
      end
      r_timeout <= w_timeout_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  // A channel may advance when counting, or when expired in auto-reload mode
  // (an expired reload channel behaves exactly like a counting one).
  always_comb begin
    w_run = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (r_state[i])
        ST_IDLE, ST_COUNT: w_run[i] = 1'b1;
        ST_EXPIRED:        w_run[i] = (RELOAD != 0);
        default:           w_run[i] = 1'b0;
      endcase
    end
  end

  // Next-state logic per channel: clear beats enable beats hold.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_count_nxt[i]   = r_count[i];
      w_timeout_nxt[i] = r_timeout[i];
      w_pulse_nxt[i]   = 1'b0;
      if (clear[i]) begin
        w_state_nxt[i]   = ST_IDLE;
        w_count_nxt[i]   = '0;
        w_timeout_nxt[i] = 1'b0;
      end else if (enable[i]) begin
        if (w_run[i]) begin
          // Increment only below the limit, so the counter can never wrap.
          if (r_count[i] < limit) begin
            w_count_nxt[i] = r_count[i] + WIDTH'(1);
            w_state_nxt[i] = ST_COUNT;
          end else begin
            w_timeout_nxt[i] = 1'b1;
            w_pulse_nxt[i]   = 1'b1;
            w_state_nxt[i]   = ST_EXPIRED;
            if (RELOAD != 0) begin
              w_count_nxt[i] = '0;
            end else begin
              w_count_nxt[i] = r_count[i];
            end
          end
        end else if (r_state[i] == ST_EXPIRED) begin
          // One-shot expired channel: frozen until clear or reset.
          w_state_nxt[i] = ST_EXPIRED;
        end else begin
          // Illegal encoding: recover to a clean idle channel.
          w_state_nxt[i]   = ST_IDLE;
          w_count_nxt[i]   = '0;
          w_timeout_nxt[i] = 1'b0;
        end
      end else begin
        // Pause: everything holds, pulse drops.
        w_state_nxt[i] = r_state[i];
      end
    end
  end

  // Fixed-priority encoder: scan downward so the lowest set index wins.
  always_comb begin
    w_first_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_timeout[i]) begin
        w_first_id = ID_W'(i);
      end else begin
        w_first_id = w_first_id;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_count
      assign count[g*WIDTH +: WIDTH] = r_count[g];
    end
  endgenerate

  assign timeout       = r_timeout;
  assign timeout_pulse = r_pulse;
  assign any_timeout   = |r_timeout;
  assign first_id      = w_first_id;

endmodule

// File: tb/tb_noc_timeout_bank.sv
// Scoreboard bench for noc_timeout_bank: a one-shot instance (d=0) and an
// auto-reload instance (d=1). The driver pushes hand-computed expectations;
// the monitor pops and compares them on each falling clock edge, or on a
// probe strobe used to look at outputs between edges.
module tb_noc_timeout_bank;

  logic        clk;
  logic        reset;
  logic        rst_probe;
  logic [4:0]  en0, clr0, en1, clr1;
  logic [9:0]  lim0, lim1;
  logic [49:0] cnt0, cnt1;
  logic [4:0]  to0, pl0, to1, pl1;
  logic        any0, any1;
  logic [2:0]  fid0, fid1;

  noc_timeout_bank #(.NUM_CH(5), .WIDTH(10), .RELOAD(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(en0), .clear(clr0), .limit(lim0),
    .count(cnt0), .timeout(to0), .timeout_pulse(pl0),
    .any_timeout(any0), .first_id(fid0)
  );

  noc_timeout_bank #(.NUM_CH(5), .WIDTH(10), .RELOAD(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(en1), .clear(clr1), .limit(lim1),
    .count(cnt1), .timeout(to1), .timeout_pulse(pl1),
    .any_timeout(any1), .first_id(fid1)
  );

  typedef struct {
    string      name;
    int         d;
    int         ch;
    logic [9:0] cnt;
    logic [4:0] to;
    logic [4:0] pl;
    logic [2:0] fid;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string name, input int d, input int ch,
                      input logic [9:0] cnt, input logic [4:0] to,
                      input logic [4:0] pl, input logic [2:0] fid);
    exp_t e;
    e.name = name; e.d = d; e.ch = ch;
    e.cnt = cnt; e.to = to; e.pl = pl; e.fid = fid;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  exp_t       m_e;
  logic [9:0] a_cnt;
  logic [4:0] a_to, a_pl;
  logic       a_any;
  logic [2:0] a_fid;
  always @(negedge clk or posedge rst_probe) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      if (m_e.d == 0) begin
        a_cnt = cnt0[m_e.ch*10 +: 10]; a_to = to0; a_pl = pl0;
        a_any = any0; a_fid = fid0;
      end else begin
        a_cnt = cnt1[m_e.ch*10 +: 10]; a_to = to1; a_pl = pl1;
        a_any = any1; a_fid = fid1;
      end
      n_chk++;
      if (a_cnt == m_e.cnt && a_to == m_e.to && a_pl == m_e.pl &&
          a_any == (|m_e.to) && a_fid == m_e.fid) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got cnt=%0d to=%b pl=%b any=%b fid=%0d, want cnt=%0d to=%b pl=%b any=%b fid=%0d",
                 m_e.name, a_cnt, a_to, a_pl, a_any, a_fid,
                 m_e.cnt, m_e.to, m_e.pl, |m_e.to, m_e.fid);
      end
    end
  end

  initial begin
    reset = 1'b0; rst_probe = 1'b0;
    en0 = 5'd0; clr0 = 5'd0; lim0 = 10'd0;
    en1 = 5'd0; clr1 = 5'd0; lim1 = 10'd0;

    // Reset state
    tick(2);
    push("reset_d0", 0, 0, 10'd0, 5'b00000, 5'b00000, 3'd0);
    push("reset_d1", 1, 1, 10'd0, 5'b00000, 5'b00000, 3'd0);
    reset = 1'b1;

    // Basic one-shot, L=3, channel 0
    lim0 = 10'd3; en0 = 5'b00001;
    tick(1); push("oneshot_cnt1", 0, 0, 10'd1, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("oneshot_cnt2", 0, 0, 10'd2, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("oneshot_cnt3", 0, 0, 10'd3, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("oneshot_exp",  0, 0, 10'd3, 5'b00001, 5'b00001, 3'd0);
    tick(1); push("oneshot_pfall",0, 0, 10'd3, 5'b00001, 5'b00000, 3'd0);
    tick(1); push("oneshot_frozen",0,0, 10'd3, 5'b00001, 5'b00000, 3'd0);
    en0 = 5'b00000; clr0 = 5'b00001;
    tick(1); push("oneshot_clear", 0, 0, 10'd0, 5'b00000, 5'b00000, 3'd0);
    clr0 = 5'b00000;

    // Pause and clear priority, L=5
    lim0 = 10'd5; en0 = 5'b00001;
    tick(3); push("pause_run3",  0, 0, 10'd3, 5'b00000, 5'b00000, 3'd0);
    en0 = 5'b00000;
    tick(4); push("pause_hold3", 0, 0, 10'd3, 5'b00000, 5'b00000, 3'd0);
    en0 = 5'b00001; clr0 = 5'b00001;
    tick(1); push("clear_beats_en", 0, 0, 10'd0, 5'b00000, 5'b00000, 3'd0);
    clr0 = 5'b00000;
    tick(5); push("reen_cnt5",   0, 0, 10'd5, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("reen_exp",    0, 0, 10'd5, 5'b00001, 5'b00001, 3'd0);
    en0 = 5'b00000; clr0 = 5'b00001;
    tick(1); clr0 = 5'b00000;

    // Auto-reload, L=2, channel 1 of the reload instance
    lim1 = 10'd2; en1 = 5'b00010;
    tick(1); push("reload_e1", 1, 1, 10'd1, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("reload_e2", 1, 1, 10'd2, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("reload_e3", 1, 1, 10'd0, 5'b00010, 5'b00010, 3'd1);
    tick(1); push("reload_e4", 1, 1, 10'd1, 5'b00010, 5'b00000, 3'd1);
    tick(1); push("reload_e5", 1, 1, 10'd2, 5'b00010, 5'b00000, 3'd1);
    tick(1); push("reload_e6", 1, 1, 10'd0, 5'b00010, 5'b00010, 3'd1);
    tick(1); push("reload_e7", 1, 1, 10'd1, 5'b00010, 5'b00000, 3'd1);
    tick(1); push("reload_e8", 1, 1, 10'd2, 5'b00010, 5'b00000, 3'd1);
    tick(1); push("reload_e9", 1, 1, 10'd0, 5'b00010, 5'b00010, 3'd1);
    en1 = 5'b00000; clr1 = 5'b00010;
    tick(1); push("reload_clear", 1, 1, 10'd0, 5'b00000, 5'b00000, 3'd0);
    clr1 = 5'b00000;

    // Multi-channel priority: channels 3 and 1 expire together, L=1
    lim0 = 10'd1; en0 = 5'b01010;
    tick(1); push("multi_cnt1",  0, 1, 10'd1, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("multi_exp1",  0, 1, 10'd1, 5'b01010, 5'b01010, 3'd1);
             push("multi_exp3",  0, 3, 10'd1, 5'b01010, 5'b01010, 3'd1);
    en0 = 5'b00000; clr0 = 5'b00010;
    tick(1); push("multi_clr1",  0, 3, 10'd1, 5'b01000, 5'b00000, 3'd3);
    clr0 = 5'b01000;
    tick(1); push("multi_clr3",  0, 3, 10'd0, 5'b00000, 5'b00000, 3'd0);
    clr0 = 5'b00000;

    // L=0: first enabled edge expires (channel 2)
    lim0 = 10'd0; en0 = 5'b00100;
    tick(1); push("l0_exp", 0, 2, 10'd0, 5'b00100, 5'b00100, 3'd2);
    en0 = 5'b00000; clr0 = 5'b00100;
    tick(1); clr0 = 5'b00000;

    // L=1023: no wrap, expiry on edge 1024
    lim0 = 10'd1023; en0 = 5'b00100;
    tick(1022); push("lmax_1022", 0, 2, 10'd1022, 5'b00000, 5'b00000, 3'd0);
    tick(1);    push("lmax_1023", 0, 2, 10'd1023, 5'b00000, 5'b00000, 3'd0);
    tick(1);    push("lmax_exp",  0, 2, 10'd1023, 5'b00100, 5'b00100, 3'd2);
    en0 = 5'b00000; clr0 = 5'b00100;
    tick(1); clr0 = 5'b00000;

    // Lower the limit below the running count
    lim0 = 10'd8; en0 = 5'b00100;
    tick(5); push("lower_cnt5", 0, 2, 10'd5, 5'b00000, 5'b00000, 3'd0);
    lim0 = 10'd2;
    tick(1); push("lower_exp",  0, 2, 10'd5, 5'b00100, 5'b00100, 3'd2);
    en0 = 5'b00000; clr0 = 5'b00100;
    tick(1); clr0 = 5'b00000;

    // Async reset with channel 4 expired and channels 0,1 counting
    lim0 = 10'd2; en0 = 5'b10000;
    tick(3); push("rst_pre_exp", 0, 4, 10'd2, 5'b10000, 5'b10000, 3'd4);
    lim0 = 10'd8; en0 = 5'b10011;
    tick(2); push("rst_pre_cnt", 0, 1, 10'd2, 5'b10000, 5'b00000, 3'd4);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    push("rst_async_ch0", 0, 0, 10'd0, 5'b00000, 5'b00000, 3'd0);
    push("rst_async_ch4", 0, 4, 10'd0, 5'b00000, 5'b00000, 3'd0);
    rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; en0 = 5'b00001;
    tick(1); push("rst_resume1", 0, 0, 10'd1, 5'b00000, 5'b00000, 3'd0);
    tick(1); push("rst_resume2", 0, 0, 10'd2, 5'b00000, 5'b00000, 3'd0);
    en0 = 5'b00000;

    tick(2);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
